spec_frame_sched: RTL and testbench
===================================

# spec_frame_sched

Ping-pong spectrum-bank scheduler that sequences the spectral denoise stage. The FFT writer fills one of two 1024-bin spectrum RAM banks. This block tracks which banks hold complete frames and starts a denoise pass only when a full bank exists and the downstream IFFT can take a whole frame. It holds the denoise `enable` level for the pass, releases the bank on the denoise `tlast`, and enforces the inter-frame gap the denoise pipeline needs. It sits between the FFT writer, the spectrum RAM read mux and the denoise stage.

## Interface
- `NFFT_LOG2`, default 10: log2 of bins per frame; a pass is 2^NFFT_LOG2 bins.
- `GAP_CYCLES`, default 4: minimum cycles `dn_enable` stays low between passes; must be at least 3.
- `TIMEOUT`, default 1100: maximum cycles in RUN waiting for `dn_tlast`; must exceed 2^NFFT_LOG2 + 2.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `sched_en`, in, 1: allows new passes to start; passes already running always complete.
- `wr_frame_done`, in, 1: one-cycle pulse; the FFT writer has finished filling bank `wr_bank`.
- `wr_bank`, out, 1: bank the FFT writer must fill next.
- `wr_stall`, out, 1: `wr_bank` is still full; the writer must not write.
- `ifft_ready`, in, 1: level; downstream can absorb a complete frame without backpressure.
- `dn_tlast`, in, 1: denoise last-bin pulse.
- `dn_enable`, out, 1: denoise enable level.
- `rd_bank`, out, 1: RAM read-mux select for the denoise address port.
- `busy`, out, 1: state is not IDLE.
- `frame_cnt`, out, 16: count of completed passes; wraps.
- `err_overrun`, out, 1: sticky; `wr_frame_done` arrived while `wr_stall` was high.
- `err_timeout`, out, 1: sticky; a pass hit the TIMEOUT limit.

## Operation
- Bank flags `full[1:0]` track which banks hold complete frames.
- On `wr_frame_done` with `!wr_stall`:
  - `full[wr_bank]` is set.
  - `wr_bank` toggles.
- On `wr_frame_done` with `wr_stall`:
  - The pulse is ignored.
  - `err_overrun` is set.
- On release:
  - `full[rd_bank]` is cleared.
  - `rd_bank` toggles.
- Set and release on the same cycle affect different banks; both take effect.
- FSM states:
  - IDLE: if `sched_en & ifft_ready & full[rd_bank]`, go to RUN next cycle and set `dn_enable`=1.
  - RUN: `dn_enable`=1 and the watchdog counts.
    - On `dn_tlast`: `dn_enable`=0, release, `frame_cnt`+1, go to GAP.
    - On watchdog == TIMEOUT-1 without `dn_tlast`: `dn_enable`=0, release, set `err_timeout`, go to GAP. `frame_cnt` does not increment.
  - GAP: `dn_enable`=0 for exactly GAP_CYCLES cycles, then go to IDLE.
- `dn_tlast` outside RUN is ignored.
- `sched_en` or `ifft_ready` falling during RUN or GAP has no effect on that pass.
- `rd_bank` is constant from RUN entry until release.

## Timing
- Reset values:
  - `dn_enable`, `busy`, `wr_stall`, `err_*` = 0.
  - `wr_bank` = `rd_bank` = 0, `full` = 0, `frame_cnt` = 0.
  - State IDLE.
- Reset mid-pass: all of the above on the next edge; the frame is discarded.
- `wr_stall` is combinational from `full[wr_bank]`.
- The start condition sampled in cycle t gives `dn_enable` high at t+1.
- Denoise nominally returns `dn_tlast` 2^NFFT_LOG2 + 2 cycles after `dn_enable` rises (1026 at default).
- `dn_enable` falls the edge after `dn_tlast` is sampled.
- Earliest next `dn_enable` rise is GAP_CYCLES+1 cycles after the fall.
- A write in progress on the other bank is never blocked by RUN.

## Structure
- Shared package `spec_pkg` holds:
  - FSM state enum `{IDLE, RUN, GAP}`.
  - Constants `SPEC_NFFT=1024`, `DN_TLAST_LAT=1026`, `DN_MIN_GAP=3`.
- One sub-module, `spec_bank_tracker`: `full` flags, `wr_bank`/`rd_bank` pointers, overrun detection, `wr_stall`.
- The top level holds the FSM, watchdog, gap counter and `frame_cnt`.

## Test plan
- Single frame:
  - Stimulus: after reset, `sched_en`=`ifft_ready`=1; pulse `wr_frame_done`; model denoise returns `dn_tlast` 1026 cycles after `dn_enable` rises.
  - Response: `dn_enable` high 1027 cycles, `rd_bank`=0, `frame_cnt`=1, `wr_bank`=1, `full`=00.
- Back-to-back:
  - Stimulus: fill bank 0, start the pass, fill bank 1 during RUN.
  - Response: second rise exactly 5 cycles after the first fall, with `rd_bank`=1.
- Overrun:
  - Stimulus: 3 `wr_frame_done` pulses with `ifft_ready`=0.
  - Response: `wr_stall`=1 after the second pulse, `err_overrun`=1 after the third, `full`=11.
- Timeout:
  - Stimulus: start a pass; never assert `dn_tlast`.
  - Response: `dn_enable` low after 1100 cycles, `err_timeout`=1, `frame_cnt` unchanged, bank released.
- Gating and mid-pass reset:
  - Stimulus: `ifft_ready`=0 with a full bank.
  - Response: no start; raise `ifft_ready` and `dn_enable` rises next cycle.
  - Stimulus: drop `rst_n` at RUN cycle 500.
  - Response: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/spec_pkg.sv
// Shared types and constants for the spectral denoise scheduling slice.
package spec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam int SPEC_NFFT    = 1024;
  localparam int DN_TLAST_LAT = 1026;
  localparam int DN_MIN_GAP   = 3;

  // Counter width able to hold values 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spec_frame_sched_if.sv
// Bank handshake between FFT writer, spectrum RAM read mux and the denoise stage.
interface spec_frame_sched_if;

  logic wr_frame_done;
  logic wr_bank;
  logic wr_stall;
  logic ifft_ready;
  logic dn_tlast;
  logic dn_enable;
  logic rd_bank;

  // Environment side: writer, downstream readiness, denoise feedback.
  modport master (
    output wr_frame_done,
    output ifft_ready,
    output dn_tlast,
    input  wr_bank,
    input  wr_stall,
    input  dn_enable,
    input  rd_bank
  );

  // Scheduler side.
  modport slave (
    input  wr_frame_done,
    input  ifft_ready,
    input  dn_tlast,
    output wr_bank,
    output wr_stall,
    output dn_enable,
    output rd_bank
  );

endinterface

// File: rtl/spec_bank_tracker.sv
// Ping-pong bank ownership: full flags, writer/reader pointers, overrun detection.
module spec_bank_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_frame_done,
  input  logic release_bank,
  output logic wr_bank,
  output logic rd_bank,
  output logic wr_stall,
  output logic rd_full,
  output logic err_overrun
);

  logic [1:0] full_reg;
  logic [1:0] full_next;
  logic       wr_bank_reg;
  logic       wr_bank_next;
  logic       rd_bank_reg;
  logic       rd_bank_next;
  logic       err_overrun_reg;
  logic       err_overrun_next;
  logic       wr_accept;

  assign wr_stall  = full_reg[wr_bank_reg];
  assign wr_accept = wr_frame_done & ~wr_stall;

  // A set and a release in the same cycle always target different banks:
  // the reader's bank is full, so the writer cannot be pointing at it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign full_next[gi] =
        (full_reg[gi] | (wr_accept && (wr_bank_reg == 1'(gi))))
        & ~(release_bank && (rd_bank_reg == 1'(gi)));
    end
  endgenerate

  always_comb begin
    wr_bank_next     = wr_bank_reg ^ wr_accept;
    rd_bank_next     = rd_bank_reg ^ release_bank;
    err_overrun_next = err_overrun_reg | (wr_frame_done & wr_stall);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_reg        <= 2'b00;
      wr_bank_reg     <= 1'b0;
      rd_bank_reg     <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      full_reg        <= full_next;
      wr_bank_reg     <= wr_bank_next;
      rd_bank_reg     <= rd_bank_next;
      err_overrun_reg <= err_overrun_next;
    end
  end

  assign wr_bank     = wr_bank_reg;
  assign rd_bank     = rd_bank_reg;
  assign rd_full     = full_reg[rd_bank_reg];
  assign err_overrun = err_overrun_reg;

endmodule

// File: rtl/spec_frame_sched.sv
// Denoise pass scheduler: starts a pass on a full bank when downstream is ready,
// releases the bank on tlast or watchdog expiry, then enforces the inter-frame gap.
module spec_frame_sched
  import spec_pkg::*;
#(
  parameter int NFFT_LOG2  = $clog2(SPEC_NFFT),
  parameter int GAP_CYCLES = DN_MIN_GAP + 1,
  parameter int TIMEOUT    = 1100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sched_en,
  spec_frame_sched_if.slave   bus,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic                err_overrun,
  output logic                err_timeout
);

  // A misconfigured TIMEOUT or GAP_CYCLES is raised to the smallest safe value
  // so a nominal pass is never cut short and the pipeline always gets its gap.
  localparam int PASS_LEN = 1 << NFFT_LOG2;
  localparam int TMO_EFF  = (TIMEOUT > PASS_LEN + 2) ? TIMEOUT : PASS_LEN + 3;
  localparam int GAP_EFF  = (GAP_CYCLES >= DN_MIN_GAP) ? GAP_CYCLES : DN_MIN_GAP;
  localparam int WD_W     = cnt_width(TMO_EFF);
  localparam int GAP_W    = cnt_width(GAP_EFF);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TMO_EFF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);

  sched_state_t     state_reg;
  sched_state_t     state_next;
  logic [WD_W-1:0]  wdog_reg;
  logic [WD_W-1:0]  wdog_next;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_next;
  logic [15:0]      frame_cnt_reg;
  logic [15:0]      frame_cnt_next;
  logic             err_timeout_reg;
  logic             err_timeout_next;

  logic release_bank;
  logic pass_done;
  logic timeout_hit;
  logic rd_full;
  logic wr_bank;
  logic rd_bank;
  logic wr_stall;

  spec_bank_tracker u_bank (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_frame_done (bus.wr_frame_done),
    .release_bank  (release_bank),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .wr_stall      (wr_stall),
    .rd_full       (rd_full),
    .err_overrun   (err_overrun)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    release_bank = 1'b0;
    pass_done    = 1'b0;
    timeout_hit  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sched_en && bus.ifft_ready && rd_full) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // tlast takes priority over the watchdog in the same cycle.
        if (bus.dn_tlast) begin
          state_next   = GAP;
          release_bank = 1'b1;
          pass_done    = 1'b1;
        end else if (wdog_reg == WD_LAST) begin
          state_next   = GAP;
          release_bank = 1'b1;
          timeout_hit  = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    wdog_next        = (state_reg == RUN) ? wdog_reg + 1'b1 : '0;
    gap_cnt_next     = (state_reg == GAP) ? gap_cnt_reg + 1'b1 : '0;
    frame_cnt_next   = frame_cnt_reg + 16'(pass_done);
    err_timeout_next = err_timeout_reg | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_reg        <= '0;
      gap_cnt_reg     <= '0;
      frame_cnt_reg   <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      wdog_reg        <= wdog_next;
      gap_cnt_reg     <= gap_cnt_next;
      frame_cnt_reg   <= frame_cnt_next;
      err_timeout_reg <= err_timeout_next;
    end
  end

  assign bus.wr_bank   = wr_bank;
  assign bus.rd_bank   = rd_bank;
  assign bus.wr_stall  = wr_stall;
  assign bus.dn_enable = (state_reg == RUN);
  assign busy          = (state_reg != IDLE);
  assign frame_cnt     = frame_cnt_reg;
  assign err_timeout   = err_timeout_reg;

endmodule

// File: tb/tb_spec_frame_sched.sv
// Directed bench: single frame, back-to-back, overrun, gating, timeout, mid-pass reset.
module tb_spec_frame_sched;
  import spec_pkg::*;

  localparam int TMO = 1100;

  logic        clk;
  logic        rst_n;
  logic        sched_en;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_overrun;
  logic        err_timeout;
  int          n_checks;
  int          n_errors;

  spec_frame_sched_if bus ();

  spec_frame_sched #(
    .NFFT_LOG2  (10),
    .GAP_CYCLES (4),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sched_en    (sched_en),
    .bus         (bus),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".dn_enable"}, 32'(bus.dn_enable), 0);
    chk({tag, ".busy"},      32'(busy), 0);
    chk({tag, ".wr_stall"},  32'(bus.wr_stall), 0);
    chk({tag, ".err_ovr"},   32'(err_overrun), 0);
    chk({tag, ".err_tmo"},   32'(err_timeout), 0);
    chk({tag, ".wr_bank"},   32'(bus.wr_bank), 0);
    chk({tag, ".rd_bank"},   32'(bus.rd_bank), 0);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, ".full"},      32'(dut.u_bank.full_reg), 0);
  endtask

  task automatic pulse_wr();
    bus.wr_frame_done = 1'b1;
    tick(1);
    bus.wr_frame_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    sched_en = 1'b0;
    bus.wr_frame_done = 1'b0;
    bus.ifft_ready = 1'b0;
    bus.dn_tlast = 1'b0;
    tick(3);
    chk_reset("rst");
    rst_n = 1'b1;

    // Single frame: bank 0 filled, pass of DN_TLAST_LAT+1 enable cycles.
    sched_en = 1'b1;
    bus.ifft_ready = 1'b1;
    pulse_wr();
    chk("s1.en_before", 32'(bus.dn_enable), 0);
    chk("s1.wr_bank", 32'(bus.wr_bank), 1);
    tick(1);
    chk("s1.rise", 32'(bus.dn_enable), 1);
    chk("s1.busy", 32'(busy), 1);
    tick(DN_TLAST_LAT);
    chk("s1.en_last", 32'(bus.dn_enable), 1);
    chk("s1.rd_bank", 32'(bus.rd_bank), 0);
    bus.dn_tlast = 1'b1;
    tick(1);
    bus.dn_tlast = 1'b0;
    chk("s1.fall", 32'(bus.dn_enable), 0);
    chk("s1.frame_cnt", 32'(frame_cnt), 1);
    chk("s1.full", 32'(dut.u_bank.full_reg), 0);
    chk("s1.wr_bank_end", 32'(bus.wr_bank), 1);
    chk("s1.rd_bank_end", 32'(bus.rd_bank), 1);

    // Back-to-back: bank 1 filled during the bank 0 pass.
    do_reset();
    pulse_wr();
    tick(1);
    chk("b2b.rise1", 32'(bus.dn_enable), 1);
    tick(10);
    bus.wr_frame_done = 1'b1;
    chk("b2b.stall_in_run", 32'(bus.wr_stall), 0);
    tick(1);
    bus.wr_frame_done = 1'b0;
    chk("b2b.wr_bank", 32'(bus.wr_bank), 0);
    chk("b2b.stall_full0", 32'(bus.wr_stall), 1);
    chk("b2b.full11", 32'(dut.u_bank.full_reg), 3);
    tick(DN_TLAST_LAT - 11);
    bus.dn_tlast = 1'b1;
    tick(1);
    bus.dn_tlast = 1'b0;
    chk("b2b.fall1", 32'(bus.dn_enable), 0);
    chk("b2b.rd_bank1", 32'(bus.rd_bank), 1);
    chk("b2b.full10", 32'(dut.u_bank.full_reg), 2);
    chk("b2b.stall_rel", 32'(bus.wr_stall), 0);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk($sformatf("b2b.gap%0d", i), 32'(bus.dn_enable), 0);
    end
    tick(1);
    chk("b2b.rise2", 32'(bus.dn_enable), 1);
    chk("b2b.rd_bank2", 32'(bus.rd_bank), 1);
    tick(DN_TLAST_LAT);
    bus.dn_tlast = 1'b1;
    tick(1);
    bus.dn_tlast = 1'b0;
    chk("b2b.frame_cnt", 32'(frame_cnt), 2);
    chk("b2b.full00", 32'(dut.u_bank.full_reg), 0);
    chk("b2b.rd_bank_end", 32'(bus.rd_bank), 0);

    // Overrun: three fills with downstream not ready.
    do_reset();
    bus.ifft_ready = 1'b0;
    pulse_wr();
    tick(1);
    chk("ovr.stall1", 32'(bus.wr_stall), 0);
    pulse_wr();
    tick(1);
    chk("ovr.stall2", 32'(bus.wr_stall), 1);
    chk("ovr.err2", 32'(err_overrun), 0);
    pulse_wr();
    tick(1);
    chk("ovr.err3", 32'(err_overrun), 1);
    chk("ovr.full", 32'(dut.u_bank.full_reg), 3);
    chk("ovr.wr_bank", 32'(bus.wr_bank), 0);
    chk("ovr.no_start", 32'(bus.dn_enable), 0);

    // Gating release, then timeout with dn_tlast never returned.
    bus.ifft_ready = 1'b1;
    tick(1);
    chk("gate.rise", 32'(bus.dn_enable), 1);
    tick(100);
    bus.ifft_ready = 1'b0;
    sched_en = 1'b0;
    tick(TMO - 101);
    chk("tmo.en_last", 32'(bus.dn_enable), 1);
    tick(1);
    chk("tmo.fall", 32'(bus.dn_enable), 0);
    chk("tmo.err", 32'(err_timeout), 1);
    chk("tmo.frame_cnt", 32'(frame_cnt), 0);
    chk("tmo.rd_bank", 32'(bus.rd_bank), 1);
    chk("tmo.full", 32'(dut.u_bank.full_reg), 2);
    chk("tmo.err_ovr", 32'(err_overrun), 1);
    tick(10);
    chk("tmo.idle", 32'(busy), 0);
    bus.dn_tlast = 1'b1;
    tick(1);
    bus.dn_tlast = 1'b0;
    tick(1);
    chk("idle.tlast_ign", 32'(frame_cnt), 0);
    chk("idle.busy", 32'(busy), 0);

    // Mid-pass reset at RUN cycle 500.
    sched_en = 1'b1;
    bus.ifft_ready = 1'b1;
    tick(1);
    chk("mrst.rise", 32'(bus.dn_enable), 1);
    chk("mrst.rd_bank", 32'(bus.rd_bank), 1);
    tick(500);
    rst_n = 1'b0;
    tick(1);
    chk_reset("mrst");
    rst_n = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
